// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// The header builder is used only when UART_ARB_TAG_EN is defined.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      XFER = 2'd2
   } arb_state_e;

   localparam logic [3:0] TagNibble = 4'hF;

   // Header byte announcing which requester owns the following bytes.
   function automatic logic [7:0] build_header(input logic [3:0] id);
      return {TagNibble, id};
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: searches upward from the
// requester after last_grant and returns the first valid index.
module uart_rr_pick #(
   parameter int NumReq = 4,
   parameter int IdW    = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] valid,
   input  logic [IdW-1:0]    last_grant,
   output logic [IdW-1:0]    grant,
   output logic              any
);

   always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      any   = 1'b0;
      // i runs 1..NumReq so the last granted requester is checked last.
      for (int i = 1; i <= NumReq; i++) begin
         idx = (int'(last_grant) + i) % NumReq;
         if (!any && valid[idx[IdW-1:0]]) begin
            any   = 1'b1;
            grant = idx[IdW-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte port between NumReq streams.
// Define UART_ARB_TAG_EN to prefix every grant with a {F, id} header byte.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NumReq     = 4,
   parameter int DataLength = 8,
   parameter int MaxBurst   = 16
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [NumReq-1:0]            i_req_valid,
   input  logic [NumReq*DataLength-1:0] i_req_data,
   input  logic [NumReq-1:0]            i_req_last,
   output logic [NumReq-1:0]            o_req_ready,
   output logic [DataLength-1:0]        o_tx_data,
   output logic                         o_tx_req,
   input  logic                         i_tx_rdy,
   output logic [$clog2(NumReq)-1:0]    o_grant_id,
   output logic                         o_busy
);

   localparam int IdW  = $clog2(NumReq);
   localparam int CntW = $clog2(MaxBurst + 1);

   arb_state_e      state;
   arb_state_e      state_nxt;
   logic [IdW-1:0]  grant_id;
   logic [CntW-1:0] count;
   logic [IdW-1:0]  pick_id;
   logic            pick_any;
   logic            beat;
   logic            msg_last;
   logic            burst_done;

   uart_rr_pick #(
      .NumReq (NumReq),
      .IdW    (IdW)
   ) u_pick (
      .valid      (i_req_valid),
      .last_grant (grant_id),
      .grant      (pick_id),
      .any        (pick_any)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         grant_id <= IdW'(NumReq - 1);
         count    <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && pick_any) begin
            grant_id <= pick_id;
            count    <= '0;
         end else if (state == XFER && beat) begin
            count <= count + CntW'(1);
         end
      end
   end

   // Valid/ready: a byte moves from the granted requester when valid and
   // ready are both high at a clock edge; ready simply mirrors i_tx_rdy.
   always_comb begin
      state_nxt   = state;
      o_req_ready = '0;
      o_tx_req    = 1'b0;
      o_tx_data   = '0;
      beat        = 1'b0;
      msg_last    = i_req_last[grant_id];
      burst_done  = (count + CntW'(1)) == CntW'(MaxBurst);
      case (state)
         IDLE: begin
            if (pick_any) begin
`ifdef UART_ARB_TAG_EN
               state_nxt = HDR;
`else
               state_nxt = XFER;
`endif
            end
         end
`ifdef UART_ARB_TAG_EN
         HDR: begin
            o_tx_req  = i_tx_rdy;
            o_tx_data = DataLength'(build_header(4'(grant_id)));
            if (i_tx_rdy) state_nxt = XFER;
         end
`endif
         XFER: begin
            o_req_ready[grant_id] = i_tx_rdy;
            o_tx_req  = i_req_valid[grant_id] & i_tx_rdy;
            o_tx_data = i_req_data[grant_id*DataLength +: DataLength];
            beat      = o_tx_req;
            // Forced release hands the remainder of a long message to a new grant.
            if (beat && (msg_last || burst_done)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign o_grant_id = grant_id;
   assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; honours UART_ARB_TAG_EN when defined.
module tb_uart_tx_arbiter;

   localparam int N = 4;
`ifdef UART_ARB_TAG_EN
   localparam int T = 1;
`else
   localparam int T = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N*8-1:0] req_data;
   logic [N-1:0]  req_last;
   logic [N-1:0]  req_ready;
   logic [7:0]    tx_data;
   logic          tx_req;
   logic          tx_rdy;
   logic [1:0]    grant_id;
   logic          busy;

   logic [8:0] src_q [N][$];
   logic [7:0] got_d[$];
   logic [3:0] got_g[$];
   int         got_c[$];
   logic [7:0] exp_d[$];
   logic [3:0] exp_g[$];
   int         exp_c[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int busy_cnt = 0;

   uart_tx_arbiter #(
      .NumReq     (N),
      .DataLength (8),
      .MaxBurst   (16)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .i_req_data  (req_data),
      .i_req_last  (req_last),
      .o_req_ready (req_ready),
      .o_tx_data   (tx_data),
      .o_tx_req    (tx_req),
      .i_tx_rdy    (tx_rdy),
      .o_grant_id  (grant_id),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      assert (act === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic bit all_empty();
      for (int k = 0; k < N; k++) if (src_q[k].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive(input bit rdy);
      logic [8:0] h;
      tx_rdy = rdy;
      for (int k = 0; k < N; k++) begin
         if (src_q[k].size() != 0) begin
            h = src_q[k][0];
            req_valid[k]      = 1'b1;
            req_data[k*8 +: 8] = h[7:0];
            req_last[k]       = h[8];
         end else begin
            req_valid[k]      = 1'b0;
            req_data[k*8 +: 8] = 8'h00;
            req_last[k]       = 1'b0;
         end
      end
   endtask

   // One clock: drive at negedge, sample just after, accepted bytes leave the sources.
   task automatic cycle(input bit rdy);
      @(negedge clk);
      drive(rdy);
      #1;
      if (busy) busy_cnt++;
      if (tx_req) begin
         got_d.push_back(tx_data);
         got_g.push_back({2'b00, grant_id});
         got_c.push_back(cyc);
      end
      for (int k = 0; k < N; k++)
         if (req_ready[k] && req_valid[k]) void'(src_q[k].pop_front());
      cyc++;
   endtask

   task automatic clear_log();
      got_d.delete(); got_g.delete(); got_c.delete();
      exp_d.delete(); exp_g.delete(); exp_c.delete();
      cyc = 0;
      busy_cnt = 0;
   endtask

   task automatic add_exp(input int g, input logic [7:0] d, input bit first);
      if (T == 1 && first) begin
         exp_d.push_back({4'hF, 4'(g)});
         exp_g.push_back(4'(g));
      end
      exp_d.push_back(d);
      exp_g.push_back(4'(g));
   endtask

   task automatic run_until_idle(input string tag, input int max);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (!done && n < max) begin
         cycle(1'b1);
         done = all_empty() && !busy;
         n++;
      end
      check({tag, " completes"}, {31'd0, done}, 32'd1);
   endtask

   task automatic check_stream(input string tag);
      int n;
      check({tag, " beat count"}, got_d.size(), exp_d.size());
      n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s data[%0d]", tag, i), {24'd0, got_d[i]}, {24'd0, exp_d[i]});
         check($sformatf("%s gid[%0d]", tag, i), {28'd0, got_g[i]}, {28'd0, exp_g[i]});
      end
      if (exp_c.size() != 0) begin
         n = (got_c.size() < exp_c.size()) ? got_c.size() : exp_c.size();
         for (int i = 0; i < n; i++)
            check($sformatf("%s cycle[%0d]", tag, i), got_c[i], exp_c[i]);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int k = 0; k < N; k++) src_q[k].delete();
      drive(1'b1);
      #1;
      check("reset grant_id", {30'd0, grant_id}, N - 1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int c;
      bit done;
      bit rdy;

      // Reset with every requester pushing data: nothing may leak out.
      rst_n     = 1'b0;
      req_valid = '1;
      req_last  = '1;
      req_data  = 32'hDEADBEEF;
      tx_rdy    = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset tx_req", {31'd0, tx_req}, 0);
      check("reset req_ready", {28'd0, req_ready}, 0);
      check("reset tx_data", {24'd0, tx_data}, 0);
      check("reset grant_id", {30'd0, grant_id}, N - 1);
      check("reset busy", {31'd0, busy}, 0);
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Three-byte message from requester 0: arbitration cycle, then back-to-back beats.
      clear_log();
      src_q[0].push_back({1'b0, 8'h11});
      src_q[0].push_back({1'b0, 8'h22});
      src_q[0].push_back({1'b1, 8'h33});
      add_exp(0, 8'h11, 1'b1);
      add_exp(0, 8'h22, 1'b0);
      add_exp(0, 8'h33, 1'b0);
      for (int i = 0; i < 3 + T; i++) exp_c.push_back(1 + i);
      run_until_idle("msg3", 20);
      check_stream("msg3");
      check("msg3 busy cycles", busy_cnt, 3 + T);

      // Four requesters, two one-byte messages each, starting from a fresh reset.
      do_reset();
      clear_log();
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < N; k++)
            src_q[k].push_back({1'b1, 4'(k), 4'(r)});
      for (int j = 0; j < 2 * N; j++) begin
         add_exp(j % N, {4'(j % N), 4'(j / N)}, 1'b1);
         if (T == 1) exp_c.push_back(j * (2 + T) + 1);
         exp_c.push_back(j * (2 + T) + 1 + T);
      end
      run_until_idle("rr", 60);
      check_stream("rr");

      // Requester 1 streams 20 bytes; forced release after 16 lets requester 2 in.
      do_reset();
      clear_log();
      for (int i = 0; i < 20; i++) src_q[1].push_back({(i == 19), 8'(8'h40 + i)});
      src_q[2].push_back({1'b1, 8'h99});
      for (int i = 0; i < 16; i++) add_exp(1, 8'(8'h40 + i), (i == 0));
      add_exp(2, 8'h99, 1'b1);
      for (int i = 16; i < 20; i++) add_exp(1, 8'(8'h40 + i), (i == 16));
      run_until_idle("burst", 80);
      check_stream("burst");

      // i_tx_rdy low for five cycles in the middle of a message.
      clear_log();
      for (int i = 0; i < 6; i++) src_q[0].push_back({(i == 5), 8'(8'h60 + i)});
      for (int i = 0; i < 6; i++) add_exp(0, 8'(8'h60 + i), (i == 0));
      c = 0;
      done = 1'b0;
      while (!done && c < 60) begin
         rdy = !(c >= 3 && c < 8);
         cycle(rdy);
         if (!rdy) begin
            check($sformatf("stall tx_req c%0d", c), {31'd0, tx_req}, 0);
            check($sformatf("stall req_ready c%0d", c), {28'd0, req_ready}, 0);
            check($sformatf("stall busy c%0d", c), {31'd0, busy}, 1);
         end
         done = all_empty() && !busy;
         c++;
      end
      check("stall completes", {31'd0, done}, 1);
      check_stream("stall");

      // Single byte from requester 3 (header first when tagging is enabled).
      clear_log();
      src_q[3].push_back({1'b1, 8'h5A});
      add_exp(3, 8'h5A, 1'b1);
      run_until_idle("tag", 20);
      check_stream("tag");

      // Asynchronous reset in the middle of a message from requester 2.
      clear_log();
      for (int i = 0; i < 10; i++) src_q[2].push_back({(i == 9), 8'(8'hC0 + i)});
      repeat (4) cycle(1'b1);
      check("pre-reset beats", got_d.size(), 3);
      @(negedge clk);
      drive(1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst busy", {31'd0, busy}, 0);
      check("midrst tx_req", {31'd0, tx_req}, 0);
      check("midrst req_ready", {28'd0, req_ready}, 0);
      check("midrst grant_id", {30'd0, grant_id}, N - 1);
      check("midrst remaining", src_q[2].size(), 7 + T);
      src_q[0].push_back({1'b1, 8'h77});
      drive(1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      clear_log();
      add_exp(0, 8'h77, 1'b1);
      for (int i = 3 - T; i < 10; i++) add_exp(2, 8'(8'hC0 + i), (i == 3 - T));
      run_until_idle("postrst", 40);
      check_stream("postrst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
